lcd_cmd_sched: RTL and testbench

//  Two-requester command scheduler in front of the 8x8 LCD image controller.

---
 rtl/lcd_cmd_sched.sv | 176 +++++++++++++++++
 tb/tb_lcd_cmd_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: two-requester command scheduler in front of the 8x8 LCD image
// controller. Each requester owns a small FIFO; commands are issued one at a
// time on the cmd/cmd_valid/busy handshake, and the final WRITE (0x0) is always
// the last command issued. Completion is flagged once the controller's done rises.
// Build option:
//   LCD_SCHED_FIXED_PRIO_EN - strict priority to requester 0 (default: round-robin).
module lcd_cmd_sched #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [3:0] req0_cmd,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_cmd,
  output logic       req1_ready,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic       grant_id,
  output logic       illegal_cmd,
  output logic       seq_done
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARB   = 3'd1,
    S_WAIT  = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Codes 0xC..0xF are not valid controller commands.
  function automatic logic is_illegal(input logic [3:0] c);
    return c[3:2] == 2'b11;
  endfunction

  state_t state, state_nx;

  logic [3:0]       mem0 [DEPTH];
  logic [3:0]       mem1 [DEPTH];
  logic [PTR_W-1:0] wp0, rp0, wp1, rp1;
  logic [PTR_W:0]   cnt0, cnt1;
  logic             full0, full1, empty0, empty1;
  logic [3:0]       head0, head1;
  logic             push0, push1, store0, store1, bad0, bad1;
  logic             pop0, pop1;
  logic             elig0, elig1;
  logic             final_seen;

  // Arbitration-stage decision (combinational, registered into the outputs)
  logic             vld_p0;
  logic             sel_p0;
  logic [3:0]       cmd_p0;

  assign full0  = (cnt0 == FULL_CNT);
  assign full1  = (cnt1 == FULL_CNT);
  assign empty0 = (cnt0 == '0);
  assign empty1 = (cnt1 == '0);
  assign head0  = mem0[rp0];
  assign head1  = mem1[rp1];

  assign req0_ready = !full0 && !final_seen;
  assign req1_ready = !full1 && !final_seen;
  assign push0  = req0_valid && req0_ready;
  assign push1  = req1_valid && req1_ready;
  assign store0 = push0 && !is_illegal(req0_cmd);
  assign store1 = push1 && !is_illegal(req1_cmd);
  assign bad0   = push0 && is_illegal(req0_cmd);
  assign bad1   = push1 && is_illegal(req1_cmd);

  // A WRITE at the head waits while the other FIFO still holds earlier work.
  // If both heads are WRITE (pushed together) either may go.
  assign elig0 = !empty0 && ((head0 != 4'h0) || empty1 || (head1 == 4'h0));
  assign elig1 = !empty1 && ((head1 != 4'h0) || empty0 || (head0 == 4'h0));

`ifdef LCD_SCHED_FIXED_PRIO_EN
  assign sel_p0 = !elig0;
`else
  logic prio;
  assign sel_p0 = elig1 && (!elig0 || prio);

  // Round-robin pointer: after each issue, favour the requester that lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       prio <= 1'b0;
    else if (vld_p0) prio <= !sel_p0;
  end
`endif

  assign cmd_p0 = sel_p0 ? head1 : head0;
  assign pop0   = vld_p0 && !sel_p0;
  assign pop1   = vld_p0 && sel_p0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nx;
  end

  // Next-state logic and issue decision
  always_comb begin
    state_nx = state;
    vld_p0   = 1'b0;
    case (state)
      S_INIT:  if (!lcd_busy) state_nx = S_ARB;
      S_ARB: begin
        if (!lcd_busy && (elig0 || elig1)) begin
          vld_p0   = 1'b1;
          state_nx = (cmd_p0 == 4'h0) ? S_FINAL : S_WAIT;
        end
      end
      S_WAIT:  state_nx = S_ARB;
      S_FINAL: if (lcd_done) state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_INIT;
    endcase
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (store0) mem0[wp0] <= req0_cmd;
    if (store1) mem1[wp1] <= req1_cmd;
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves the count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp0  <= '0;
      rp0  <= '0;
      cnt0 <= '0;
      wp1  <= '0;
      rp1  <= '0;
      cnt1 <= '0;
    end else begin
      if (store0) wp0 <= wp0 + PTR_W'(1);
      if (pop0)   rp0 <= rp0 + PTR_W'(1);
      if (store1) wp1 <= wp1 + PTR_W'(1);
      if (pop1)   rp1 <= rp1 + PTR_W'(1);
      cnt0 <= cnt0 + {{PTR_W{1'b0}}, store0} - {{PTR_W{1'b0}}, pop0};
      cnt1 <= cnt1 + {{PTR_W{1'b0}}, store1} - {{PTR_W{1'b0}}, pop1};
    end
  end

  // Once a WRITE is accepted, no further pushes are taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) final_seen <= 1'b0;
    else       final_seen <= final_seen
                             | (store0 && (req0_cmd == 4'h0))
                             | (store1 && (req1_cmd == 4'h0));
  end

  // Registered controller interface and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_cmd       <= 4'h0;
      lcd_cmd_valid <= 1'b0;
      grant_id      <= 1'b0;
      illegal_cmd   <= 1'b0;
      seq_done      <= 1'b0;
    end else begin
      lcd_cmd_valid <= vld_p0;
      if (vld_p0) begin
        lcd_cmd  <= cmd_p0;
        grant_id <= sel_p0;
      end
      illegal_cmd <= bad0 || bad1;
      seq_done    <= seq_done || ((state == S_FINAL) && lcd_done);
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Testbench for lcd_cmd_sched: a cycle table covering arbitration, illegal
// codes and busy stalls, plus hand-written sequences for reset, FIFO-full,
// final WRITE ordering and reset in the middle of a sequence.
module tb_lcd_cmd_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_cmd, req1_cmd;
  logic       req0_ready, req1_ready;
  logic       lcd_busy, lcd_done;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid, grant_id, illegal_cmd, seq_done;

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];

  lcd_cmd_sched #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .grant_id(grant_id),
    .illegal_cmd(illegal_cmd), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {req0_ready, req1_ready, lcd_cmd_valid, lcd_cmd, grant_id, illegal_cmd, seq_done};

  typedef struct {
    logic       r0v;
    logic [3:0] r0c;
    logic       r1v;
    logic [3:0] r1c;
    logic       busy;
    logic [9:0] want;
  } vec_t;

  vec_t tv [21];

  function automatic logic [9:0] ex(input logic r0, input logic r1, input logic v,
                                    input logic [3:0] c, input logic g,
                                    input logic il, input logic sd);
    return {r0, r1, v, c, g, il, sd};
  endfunction

  function automatic vec_t mk(input logic a, input logic [3:0] ac, input logic b,
                              input logic [3:0] bc, input logic bz, input logic [9:0] w);
    vec_t t;
    t.r0v = a; t.r0c = ac; t.r1v = b; t.r1c = bc; t.busy = bz; t.want = w;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_cmd = 4'h0;
    req1_valid = 1'b0; req1_cmd = 4'h0;
    lcd_done   = 1'b0;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset(input logic busy_lvl);
    idle_inputs();
    lcd_busy = busy_lvl;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Run n cycles with inputs as they are, recording every issued command.
  task automatic collect(input int n);
    q.delete();
    for (int k = 0; k < n; k++) begin
      #4;
      if (lcd_cmd_valid) q.push_back(int'(lcd_cmd));
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input int who, input logic [3:0] c, output logic rdy);
    if (who == 0) begin req0_valid = 1'b1; req0_cmd = c; end
    else          begin req1_valid = 1'b1; req1_cmd = c; end
    #4 rdy = (who == 0) ? req0_ready : req1_ready;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    logic rdy;
    int   lat;
    bit   found;
    reset = 1'b1;
    idle_inputs();
    lcd_busy = 1'b1;

    // ---------------- Cycle table ----------------
    tv[0]  = mk(1, 4'h3, 1, 4'h6, 0, ex(1,1,0,4'h0,0,0,0));
    tv[1]  = mk(1, 4'h4, 1, 4'h7, 0, ex(1,1,0,4'h0,0,0,0));
    tv[2]  = mk(1, 4'h5, 1, 4'h8, 0, ex(1,1,1,4'h3,0,0,0));
    tv[3]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h3,0,0,0));
`ifdef LCD_SCHED_FIXED_PRIO_EN
    tv[4]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h4,0,0,0));
    tv[5]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h4,0,0,0));
    tv[6]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h5,0,0,0));
    tv[7]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h5,0,0,0));
    tv[8]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h6,1,0,0));
    tv[9]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h6,1,0,0));
    tv[10] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h7,1,0,0));
    tv[11] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h7,1,0,0));
`else
    tv[4]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h6,1,0,0));
    tv[5]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h6,1,0,0));
    tv[6]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h4,0,0,0));
    tv[7]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h4,0,0,0));
    tv[8]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h7,1,0,0));
    tv[9]  = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h7,1,0,0));
    tv[10] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h5,0,0,0));
    tv[11] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h5,0,0,0));
`endif
    tv[12] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h8,1,0,0));
    tv[13] = mk(0, 4'h0, 1, 4'hD, 0, ex(1,1,0,4'h8,1,0,0));
    tv[14] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h8,1,1,0));
    tv[15] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h8,1,0,0));
    tv[16] = mk(1, 4'h2, 0, 4'h0, 1, ex(1,1,0,4'h8,1,0,0));
    tv[17] = mk(0, 4'h0, 0, 4'h0, 1, ex(1,1,0,4'h8,1,0,0));
    tv[18] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h8,1,0,0));
    tv[19] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,1,4'h2,0,0,0));
    tv[20] = mk(0, 4'h0, 0, 4'h0, 0, ex(1,1,0,4'h2,0,0,0));

    do_reset(1'b0);
    for (int i = 0; i < 21; i++) begin
      req0_valid = tv[i].r0v; req0_cmd = tv[i].r0c;
      req1_valid = tv[i].r1v; req1_cmd = tv[i].r1c;
      lcd_busy   = tv[i].busy;
      #4 chk($sformatf("vec%0d", i), int'(outs), int'(tv[i].want));
      @(posedge clk); #1;
    end
    idle_inputs();

    // ---------------- Reset state, long busy, single issue ----------------
    do_reset(1'b1);
    #4 chk("reset_outputs", int'(outs), int'(ex(1,1,0,4'h0,0,0,0)));
    @(posedge clk); #1;
    collect(64);
    chk("busy_init_no_issue", q.size(), 0);
    lcd_busy = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    push(0, 4'h1, rdy);
    chk("t1_push_ready", int'(rdy), 1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      #4;
      if (lcd_cmd_valid) begin lat = k + 0; break; end
      @(posedge clk); #1;
    end
    chk("t1_latency", lat, 2);
    chk("t1_cmd", int'(lcd_cmd), 1);
    chk("t1_grant", int'(grant_id), 0);
    @(posedge clk); #1;
    collect(10);
    chk("t1_single_strobe", q.size(), 0);

    // ---------------- FIFO full while controller busy ----------------
    do_reset(1'b1);
    for (int i = 1; i <= 5; i++) begin
      push(0, 4'(i), rdy);
      chk($sformatf("t3_ready%0d", i), int'(rdy), (i <= 4) ? 1 : 0);
    end
    lcd_busy = 1'b0;
    collect(16);
    chk("t3_count", q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order%0d", i), (i < q.size()) ? q[i] : -1, i + 1);

    // ---------------- Final WRITE ordering and completion ----------------
    do_reset(1'b1);
    push(1, 4'h9, rdy);
    push(1, 4'hA, rdy);
    push(0, 4'h0, rdy);
    chk("t5_write_accepted", int'(rdy), 1);
    #4 chk("t5_ready_after_write", int'({req0_ready, req1_ready}), 0);
    @(posedge clk); #1;
    lcd_busy = 1'b0;
    collect(16);
    chk("t5_count", q.size(), 3);
    chk("t5_first",  (q.size() > 0) ? q[0] : -1, 9);
    chk("t5_second", (q.size() > 1) ? q[1] : -1, 10);
    chk("t5_last",   (q.size() > 2) ? q[2] : -1, 0);
    #4 chk("t5_seq_before_done", int'(seq_done), 0);
    @(posedge clk); #1;
    lcd_done = 1'b1;
    @(posedge clk); #1;
    lcd_done = 1'b0;
    #4 chk("t5_seq_done", int'(seq_done), 1);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_cmd = 4'h5;
    collect(6);
    chk("t5_done_no_issue", q.size(), 0);
    #4 chk("t5_done_blocked", int'({seq_done, req0_ready, req1_ready}), 3'b100);
    @(posedge clk); #1;
    idle_inputs();

    // ---------------- Reset while in WAIT with entries queued ----------------
    do_reset(1'b1);
    push(0, 4'h1, rdy);
    push(0, 4'h2, rdy);
    push(1, 4'h3, rdy);
    lcd_busy = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #4;
      if (lcd_cmd_valid) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("t6_reached_wait", int'(found), 1);
    reset = 1'b1;
    #1 chk("t6_async_reset", int'(outs), int'(ex(1,1,0,4'h0,0,0,0)));
    @(posedge clk); #1;
    reset = 1'b0;
    collect(10);
    chk("t6_fifos_empty", q.size(), 0);
    #4 chk("t6_outputs_after", int'(outs), int'(ex(1,1,0,4'h0,0,0,0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
